sargantana_itag_ctrl: RTL and testbench

// Initiator for the I-cache tag/valid array: drives req/we/vbit/flush/data/addr into the tag memory and

---
 rtl/sargantana_itag_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sargantana_itag_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_itag_ctrl.sv
// I-cache tag/valid array controller: serialises lookups and refills against a 1-cycle-latency tag memory.
// Optional SARGANTANA_ITAG_MULTIHIT_CHK_EN adds multi-hit detection ports (multihit_o, multihit_sticky_o).
module sargantana_itag_ctrl #(
  parameter int unsigned N_WAY = 4,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned IDX_W = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   lkp_valid_i,
  output logic                   lkp_ready_o,
  input  logic [IDX_W-1:0]       lkp_idx_i,
  input  logic [TAG_W-1:0]       lkp_tag_i,
  output logic                   res_valid_o,
  output logic                   res_hit_o,
  output logic [N_WAY-1:0]       res_way_o,
  input  logic                   rfl_valid_i,
  output logic                   rfl_ready_o,
  input  logic [IDX_W-1:0]       rfl_idx_i,
  input  logic [TAG_W-1:0]       rfl_tag_i,
  output logic                   rfl_done_o,
  output logic [N_WAY-1:0]       rfl_way_o,
  output logic [N_WAY-1:0]       tag_req_o,
  output logic                   tag_we_o,
  output logic                   tag_vbit_o,
  output logic                   tag_flush_o,
  output logic [TAG_W-1:0]       tag_data_o,
  output logic [IDX_W-1:0]       tag_addr_o,
  input  logic [N_WAY*TAG_W-1:0] tag_way_i,
  input  logic [N_WAY-1:0]       tag_vbit_i
`ifdef SARGANTANA_ITAG_MULTIHIT_CHK_EN
  ,
  output logic                   multihit_o,
  output logic                   multihit_sticky_o
`endif
);

  localparam int unsigned PTR_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LKP_RD = 3'd1;
  localparam logic [2:0] RFL_RD = 3'd2;
  localparam logic [2:0] RFL_WR = 3'd3;
  localparam logic [2:0] FLUSH  = 3'd4;

  logic [2:0]       state, state_d;
  logic [PTR_W-1:0] rr_ptr;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_WAY-1:0] victim_q, victim_d;
  logic [N_WAY-1:0] match, hit_way;
  logic             hit_found, inv_found, all_valid;
  int unsigned      match_cnt;

  // Tag compare against the latched lookup tag; lowest matching way wins.
  always_comb begin
    match     = '0;
    hit_way   = '0;
    hit_found = 1'b0;
    match_cnt = 0;
    for (int unsigned w = 0; w < N_WAY; w++) begin
      match[w] = tag_vbit_i[w] && (tag_way_i[w*TAG_W +: TAG_W] == tag_q);
      if (match[w]) begin
        match_cnt = match_cnt + 1;
        if (!hit_found) begin
          hit_way[w] = 1'b1;
          hit_found  = 1'b1;
        end
      end
    end
  end

  // Victim: lowest invalid way, else the round-robin way.
  always_comb begin
    victim_d  = '0;
    inv_found = 1'b0;
    all_valid = &tag_vbit_i;
    for (int unsigned w = 0; w < N_WAY; w++) begin
      if (!tag_vbit_i[w] && !inv_found) begin
        victim_d[w] = 1'b1;
        inv_found   = 1'b1;
      end
    end
    if (!inv_found) victim_d = N_WAY'(1) << rr_ptr;
  end

  always_comb begin
    state_d     = state;
    lkp_ready_o = 1'b0;
    rfl_ready_o = 1'b0;
    res_valid_o = 1'b0;
    res_hit_o   = 1'b0;
    res_way_o   = '0;
    rfl_done_o  = 1'b0;
    rfl_way_o   = '0;
    tag_req_o   = '0;
    tag_we_o    = 1'b0;
    tag_vbit_o  = 1'b0;
    tag_flush_o = 1'b0;
    tag_data_o  = '0;
    tag_addr_o  = '0;
    if (rst_i) begin
      state_d = IDLE;
    end else if (flush_i) begin
      tag_flush_o = 1'b1;
      state_d     = FLUSH;
    end else begin
      case (state)
        IDLE: begin
          rfl_ready_o = 1'b1;
          lkp_ready_o = !rfl_valid_i;
          if (rfl_valid_i) begin
            tag_req_o  = '1;
            tag_addr_o = rfl_idx_i;
            state_d    = RFL_RD;
          end else if (lkp_valid_i) begin
            tag_req_o  = '1;
            tag_addr_o = lkp_idx_i;
            state_d    = LKP_RD;
          end
        end
        LKP_RD: begin
          res_valid_o = 1'b1;
          res_hit_o   = |match;
          res_way_o   = hit_way;
          state_d     = IDLE;
        end
        RFL_RD: state_d = RFL_WR;
        RFL_WR: begin
          tag_req_o  = victim_q;
          tag_we_o   = 1'b1;
          tag_vbit_o = 1'b1;
          tag_data_o = tag_q;
          tag_addr_o = idx_q;
          rfl_done_o = 1'b1;
          rfl_way_o  = victim_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
    end else begin
      state <= state_d;
      if (flush_i || state == FLUSH) begin
        rr_ptr <= '0;
      end else if (state == RFL_RD) begin
        victim_q <= victim_d;
        if (all_valid) rr_ptr <= rr_ptr + PTR_W'(1);
      end else if (state == IDLE) begin
        if (rfl_valid_i) begin
          tag_q <= rfl_tag_i;
          idx_q <= rfl_idx_i;
        end else if (lkp_valid_i) begin
          tag_q <= lkp_tag_i;
        end
      end
    end
  end

`ifdef SARGANTANA_ITAG_MULTIHIT_CHK_EN
  assign multihit_o = res_valid_o && (match_cnt > 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           multihit_sticky_o <= 1'b0;
    else if (flush_i)    multihit_sticky_o <= 1'b0;
    else if (multihit_o) multihit_sticky_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Directed bench for sargantana_itag_ctrl with a behavioural 1-cycle-latency tag memory.
module tb_sargantana_itag_ctrl;
  localparam int unsigned N_WAY = 4;
  localparam int unsigned TAG_W = 20;
  localparam int unsigned IDX_W = 6;

  logic clk = 1'b0;
  logic rst, flush_i, lkp_valid_i, rfl_valid_i;
  logic [IDX_W-1:0] lkp_idx_i, rfl_idx_i;
  logic [TAG_W-1:0] lkp_tag_i, rfl_tag_i;
  logic lkp_ready_o, rfl_ready_o, res_valid_o, res_hit_o, rfl_done_o;
  logic [N_WAY-1:0] res_way_o, rfl_way_o, tag_req_o;
  logic tag_we_o, tag_vbit_o, tag_flush_o;
  logic [TAG_W-1:0] tag_data_o;
  logic [IDX_W-1:0] tag_addr_o;
  logic [N_WAY*TAG_W-1:0] rd_tag;
  logic [N_WAY-1:0] rd_v;
`ifdef SARGANTANA_ITAG_MULTIHIT_CHK_EN
  logic multihit_o, multihit_sticky_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [TAG_W-1:0] m_tag [64][N_WAY];
  logic             m_v   [64][N_WAY];

  always #5 clk = ~clk;

  sargantana_itag_ctrl #(.N_WAY(N_WAY), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_idx_i(lkp_idx_i), .lkp_tag_i(lkp_tag_i),
    .res_valid_o(res_valid_o), .res_hit_o(res_hit_o), .res_way_o(res_way_o),
    .rfl_valid_i(rfl_valid_i), .rfl_ready_o(rfl_ready_o), .rfl_idx_i(rfl_idx_i), .rfl_tag_i(rfl_tag_i),
    .rfl_done_o(rfl_done_o), .rfl_way_o(rfl_way_o),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o), .tag_flush_o(tag_flush_o),
    .tag_data_o(tag_data_o), .tag_addr_o(tag_addr_o), .tag_way_i(rd_tag), .tag_vbit_i(rd_v)
`ifdef SARGANTANA_ITAG_MULTIHIT_CHK_EN
    , .multihit_o(multihit_o), .multihit_sticky_o(multihit_sticky_o)
`endif
  );

  // Tag memory: synchronous write, registered read, flush clears every valid bit.
  always @(posedge clk) begin
    if (rst || tag_flush_o) begin
      for (int s = 0; s < 64; s++)
        for (int w = 0; w < N_WAY; w++) begin
          m_v[s][w] <= 1'b0;
          if (rst) m_tag[s][w] <= '0;
        end
    end else if (tag_we_o) begin
      for (int w = 0; w < N_WAY; w++)
        if (tag_req_o[w]) begin
          m_tag[tag_addr_o][w] <= tag_data_o;
          m_v[tag_addr_o][w]   <= tag_vbit_o;
        end
    end
    if (rst) begin
      rd_tag <= '0;
      rd_v   <= '0;
    end else if (|tag_req_o && !tag_we_o) begin
      for (int w = 0; w < N_WAY; w++) begin
        rd_tag[w*TAG_W +: TAG_W] <= m_tag[tag_addr_o][w];
        rd_v[w]                  <= m_v[tag_addr_o][w];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                           input logic [N_WAY-1:0] exp_way);
    rfl_valid_i = 1'b1; rfl_idx_i = idx; rfl_tag_i = tg;
    #1;
    chk("rfl_ready", rfl_ready_o, 1);
    chk("rfl_rd_req", tag_req_o, 4'hF);
    chk("rfl_rd_we", tag_we_o, 0);
    chk("rfl_rd_addr", tag_addr_o, idx);
    tick();
    rfl_valid_i = 1'b0;
    #1;
    chk("rfl_rdwait_req", tag_req_o, 0);
    chk("rfl_rdwait_done", rfl_done_o, 0);
    tick();
    #1;
    chk("rfl_done", rfl_done_o, 1);
    chk("rfl_way", rfl_way_o, exp_way);
    chk("rfl_wr_req", tag_req_o, exp_way);
    chk("rfl_wr_we", tag_we_o, 1);
    chk("rfl_wr_vbit", tag_vbit_o, 1);
    chk("rfl_wr_data", tag_data_o, tg);
    chk("rfl_wr_addr", tag_addr_o, idx);
    tick();
  endtask

  task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                           input logic exp_hit, input logic [N_WAY-1:0] exp_way, input logic exp_mh);
    lkp_valid_i = 1'b1; lkp_idx_i = idx; lkp_tag_i = tg;
    #1;
    chk("lkp_ready", lkp_ready_o, 1);
    chk("lkp_req", tag_req_o, 4'hF);
    chk("lkp_addr", tag_addr_o, idx);
    chk("lkp_accept_novalid", res_valid_o, 0);
    tick();
    lkp_valid_i = 1'b0;
    #1;
    chk("res_valid", res_valid_o, 1);
    chk("res_hit", res_hit_o, exp_hit);
    chk("res_way", res_way_o, exp_way);
`ifdef SARGANTANA_ITAG_MULTIHIT_CHK_EN
    chk("multihit", multihit_o, exp_mh);
`else
    if (exp_mh) chk("multihit_resolve_lowest", res_way_o, exp_way);
`endif
    tick();
    chk("res_pulse_end", res_valid_o, 0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; lkp_valid_i = 1'b1; rfl_valid_i = 1'b0;
    lkp_idx_i = '0; lkp_tag_i = '0; rfl_idx_i = '0; rfl_tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lkp_ready", lkp_ready_o, 0);
    chk("rst_rfl_ready", rfl_ready_o, 0);
    chk("rst_tag_req", tag_req_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_tag_flush", tag_flush_o, 0);
    lkp_valid_i = 1'b0;
    rst = 1'b0;
    tick();

    // 1: refill into empty set, then hit
    do_refill(6'd5, 20'h00ABC, 4'b0001);
    do_lookup(6'd5, 20'h00ABC, 1'b1, 4'b0001, 1'b0);

    // 2: fill set 3, then round-robin replacement
    do_refill(6'd3, 20'h00100, 4'b0001);
    do_refill(6'd3, 20'h00101, 4'b0010);
    do_refill(6'd3, 20'h00102, 4'b0100);
    do_refill(6'd3, 20'h00103, 4'b1000);
    do_refill(6'd3, 20'h00104, 4'b0001);
    do_refill(6'd3, 20'h00105, 4'b0010);
    do_lookup(6'd3, 20'h00105, 1'b1, 4'b0010, 1'b0);
    do_lookup(6'd3, 20'h00103, 1'b1, 4'b1000, 1'b0);

    // 3: miss
    do_lookup(6'd3, 20'h12345, 1'b0, 4'b0000, 1'b0);

    // 4: flush during LKP_RD, held for two cycles
    lkp_valid_i = 1'b1; lkp_idx_i = 6'd5; lkp_tag_i = 20'h00ABC;
    #1;
    chk("fl_lkp_ready", lkp_ready_o, 1);
    tick();
    lkp_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fl_no_res", res_valid_o, 0);
    chk("fl_strobe", tag_flush_o, 1);
    chk("fl_req", tag_req_o, 0);
    tick();
    #1;
    chk("fl_held_strobe", tag_flush_o, 1);
    chk("fl_held_rfl_ready", rfl_ready_o, 0);
    chk("fl_held_no_res", res_valid_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fl_state_strobe", tag_flush_o, 0);
    chk("fl_state_lkp_ready", lkp_ready_o, 0);
    chk("fl_state_rfl_ready", rfl_ready_o, 0);
    tick();
    do_lookup(6'd5, 20'h00ABC, 1'b0, 4'b0000, 1'b0);

    // rr_ptr returned to 0 by the flush
    do_refill(6'd3, 20'h00200, 4'b0001);
    do_refill(6'd3, 20'h00201, 4'b0010);
    do_refill(6'd3, 20'h00202, 4'b0100);
    do_refill(6'd3, 20'h00203, 4'b1000);
    do_refill(6'd3, 20'h00204, 4'b0001);

    // 5: simultaneous refill and lookup
    rfl_valid_i = 1'b1; rfl_idx_i = 6'd7; rfl_tag_i = 20'h00055;
    lkp_valid_i = 1'b1; lkp_idx_i = 6'd7; lkp_tag_i = 20'h00055;
    #1;
    chk("both_rfl_ready", rfl_ready_o, 1);
    chk("both_lkp_ready", lkp_ready_o, 0);
    chk("both_addr", tag_addr_o, 7);
    tick();
    rfl_valid_i = 1'b0;
    #1;
    chk("both_rd_lkp_ready", lkp_ready_o, 0);
    chk("both_rd_res", res_valid_o, 0);
    tick();
    #1;
    chk("both_wr_lkp_ready", lkp_ready_o, 0);
    chk("both_wr_done", rfl_done_o, 1);
    chk("both_wr_way", rfl_way_o, 4'b0001);
    tick();
    do_lookup(6'd7, 20'h00055, 1'b1, 4'b0001, 1'b0);

    // reset in the middle of a refill
    rfl_valid_i = 1'b1; rfl_idx_i = 6'd9; rfl_tag_i = 20'h00099;
    tick();
    rfl_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_done", rfl_done_o, 0);
    chk("midrst_we", tag_we_o, 0);
    chk("midrst_req", tag_req_o, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_idle_ready", rfl_ready_o, 1);
    tick();

    // 6: duplicate tag in ways 1 and 2 resolves to way 1
    do_refill(6'd0, 20'h00001, 4'b0001);
    do_refill(6'd0, 20'h00007, 4'b0010);
    do_refill(6'd0, 20'h00007, 4'b0100);
    do_refill(6'd0, 20'h00002, 4'b1000);
    do_lookup(6'd0, 20'h00007, 1'b1, 4'b0010, 1'b1);
`ifdef SARGANTANA_ITAG_MULTIHIT_CHK_EN
    chk("mh_sticky_set", multihit_sticky_o, 1);
    do_lookup(6'd0, 20'h00002, 1'b1, 4'b1000, 1'b0);
    chk("mh_sticky_hold", multihit_sticky_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("mh_sticky_clr", multihit_sticky_o, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
